// File: rtl/drive_mode_controller.sv
// Two-wheel drive controller: decodes UART command bytes into MANUAL moves or an AUTO
// wall-avoid cycle, debounces the wall sensor, and applies a MANUAL command watchdog.
module drive_mode_controller #(
    parameter int unsigned CNT_W           = 28,
    parameter int unsigned BACK_CYCLES     = 50_000_000,
    parameter int unsigned TURN_CYCLES     = 50_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CMD_TIMEOUT     = 0,
    parameter bit          TURN_ALT        = 1'b1
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    input  logic       wall_n,
    output logic       motor_en,
    output logic       motor_dir_l,
    output logic       motor_dir_r,
    output logic [1:0] mode,
    output logic [1:0] auto_state,
    output logic       wall_det
);

    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    if (BACK_CYCLES < 1 || BACK_CYCLES > CNT_MAX) begin : g_bad_back
        $error("BACK_CYCLES out of range for CNT_W");
    end
    if (TURN_CYCLES < 1 || TURN_CYCLES > CNT_MAX) begin : g_bad_turn
        $error("TURN_CYCLES out of range for CNT_W");
    end
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > CNT_MAX) begin : g_bad_deb
        $error("DEBOUNCE_CYCLES out of range for CNT_W");
    end
    if (CMD_TIMEOUT > CNT_MAX) begin : g_bad_wd
        $error("CMD_TIMEOUT out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] BACK_LAST = CNT_W'(BACK_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam bit               WD_EN     = (CMD_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] WD_LAST   = WD_EN ? CNT_W'(CMD_TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [7:0] CODE_UP    = 8'd9;
    localparam logic [7:0] CODE_DOWN  = 8'd7;
    localparam logic [7:0] CODE_LEFT  = 8'd3;
    localparam logic [7:0] CODE_RIGHT = 8'd4;
    localparam logic [7:0] CODE_STOP  = 8'd5;
    localparam logic [7:0] CODE_AUTO  = 8'd6;

    typedef enum logic [1:0] {M_IDLE = 2'd0, M_MANUAL = 2'd1, M_AUTO = 2'd2} mode_e;
    typedef enum logic [1:0] {A_FWD = 2'd0, A_BACK = 2'd1, A_TURN = 2'd2} auto_e;
    typedef enum logic [2:0] {ACT_STOP, ACT_UP, ACT_DOWN, ACT_LEFT, ACT_RIGHT} act_e;

    // Wall sensor: 2-flop synchroniser (idle-high raw input) followed by debounce.
    logic             wall_s1_q, wall_s2_q;
    logic             wall_sync;
    logic             wall_det_q;
    logic [CNT_W-1:0] deb_cnt_q;

    assign wall_sync = ~wall_s2_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wall_s1_q  <= 1'b1;
            wall_s2_q  <= 1'b1;
            wall_det_q <= 1'b0;
            deb_cnt_q  <= '0;
        end else begin
            wall_s1_q <= wall_n;
            wall_s2_q <= wall_s1_q;
            if (wall_sync == wall_det_q) begin
                deb_cnt_q <= '0;
            end else if (deb_cnt_q == DEB_LAST) begin
                deb_cnt_q  <= '0;
                wall_det_q <= wall_sync;
            end else begin
                deb_cnt_q <= deb_cnt_q + CNT_ONE;
            end
        end
    end

    mode_e            mode_q, mode_d;
    auto_e            auto_q, auto_d;
    act_e             act_q, act_d, cmd_act;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             turn_r_q, turn_r_d;
    logic             en_q, dl_q, dr_q;
    logic [2:0]       drive_d;
    logic             cmd_known, cmd_take;

    always_comb begin
        cmd_act   = ACT_STOP;
        cmd_known = 1'b1;
        case (cmd_data)
            CODE_UP:    cmd_act = ACT_UP;
            CODE_DOWN:  cmd_act = ACT_DOWN;
            CODE_LEFT:  cmd_act = ACT_LEFT;
            CODE_RIGHT: cmd_act = ACT_RIGHT;
            CODE_STOP:  cmd_act = ACT_STOP;
            CODE_AUTO:  cmd_act = ACT_STOP;
            default:    cmd_known = 1'b0;
        endcase
        // AUTO re-issued while already in AUTO is treated as noise.
        cmd_take = cmd_valid && cmd_known && !(cmd_data == CODE_AUTO && mode_q == M_AUTO);
    end

    always_comb begin
        mode_d   = mode_q;
        auto_d   = auto_q;
        act_d    = act_q;
        phase_d  = phase_q;
        wd_d     = wd_q;
        turn_r_d = turn_r_q;
        if (cmd_take) begin
            wd_d    = '0;
            auto_d  = A_FWD;
            phase_d = '0;
            if (cmd_data == CODE_AUTO) begin
                mode_d = M_AUTO;
            end else begin
                mode_d = M_MANUAL;
                act_d  = cmd_act;
            end
        end else if (mode_q == M_AUTO) begin
            case (auto_q)
                A_FWD: begin
                    if (wall_det_q) begin
                        auto_d  = A_BACK;
                        phase_d = '0;
                    end
                end
                A_BACK: begin
                    if (phase_q == BACK_LAST) begin
                        auto_d  = A_TURN;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + CNT_ONE;
                    end
                end
                A_TURN: begin
                    if (phase_q == TURN_LAST) begin
                        auto_d  = A_FWD;
                        phase_d = '0;
                        if (TURN_ALT) turn_r_d = ~turn_r_q;
                    end else begin
                        phase_d = phase_q + CNT_ONE;
                    end
                end
                default: begin
                    auto_d  = A_FWD;
                    phase_d = '0;
                end
            endcase
        end else if (mode_q == M_MANUAL && WD_EN) begin
            // Watchdog saturates at its last value so the stop stays latched.
            if (wd_q == WD_LAST) begin
                act_d = ACT_STOP;
            end else begin
                wd_d = wd_q + CNT_ONE;
            end
        end
    end

    always_comb begin
        drive_d = 3'b011;
        if (mode_d == M_MANUAL) begin
            case (act_d)
                ACT_UP:    drive_d = 3'b101;
                ACT_DOWN:  drive_d = 3'b110;
                ACT_LEFT:  drive_d = 3'b100;
                ACT_RIGHT: drive_d = 3'b111;
                default:   drive_d = 3'b011;
            endcase
        end else if (mode_d == M_AUTO) begin
            case (auto_d)
                A_FWD:   drive_d = 3'b101;
                A_BACK:  drive_d = 3'b110;
                A_TURN:  drive_d = turn_r_d ? 3'b111 : 3'b100;
                default: drive_d = 3'b011;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mode_q   <= M_IDLE;
            auto_q   <= A_FWD;
            act_q    <= ACT_STOP;
            phase_q  <= '0;
            wd_q     <= '0;
            turn_r_q <= 1'b0;
            en_q     <= 1'b0;
            dl_q     <= 1'b1;
            dr_q     <= 1'b1;
        end else begin
            mode_q   <= mode_d;
            auto_q   <= auto_d;
            act_q    <= act_d;
            phase_q  <= phase_d;
            wd_q     <= wd_d;
            turn_r_q <= turn_r_d;
            en_q     <= drive_d[2];
            dl_q     <= drive_d[1];
            dr_q     <= drive_d[0];
        end
    end

    assign motor_en    = en_q;
    assign motor_dir_l = dl_q;
    assign motor_dir_r = dr_q;
    assign mode        = mode_q;
    assign auto_state  = auto_q;
    assign wall_det    = wall_det_q;

endmodule
